seq_detect_param: RTL and testbench

Parametrised, run-time programmable serial pattern detector. It is the next-generation replacement for the fixed 4-bit "1101" detector. Generalisations over the fixed detector:
- pattern width set by parameter; pattern loadable at run time
- selectable Mealy/Moore output timing
- selectable overlapping/non-overlapping detection
- sample-enable input
- saturating match counter

It sits on the single-bit serial input path and feeds a match strobe and a match count to downstream control/status logic.

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/sat_counter.sv | 36 +++
 rtl/seq_detect_param.sv | 93 +++++++++
 tb/tb_seq_detect_param.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic {
    MODE_MEALY = 1'b0,
    MODE_MOORE = 1'b1
  } out_mode_e;

  localparam logic [3:0] PAT_DEFAULT_4 = 4'b1101;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign sat = &cnt_q;
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Run-time programmable serial pattern detector with Mealy/Moore output,
// optional overlapping detection and a saturating match counter.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W       = 4,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(PAT_DEFAULT_4),
  parameter int               CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic [PAT_W-1:0] pat,
  input  logic             pat_load,
  input  logic             overlap_en,
  input  logic             mode_moore,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("seq_detect_param: PAT_W out of range");
  end

  localparam int               FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat_q,  pat_d;
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              y_q,    y_d;

  logic [PAT_W-1:0]  shift_w;
  logic              fill_full;
  logic              hit;

  // Window formed by the held history plus the bit arriving this cycle.
  assign shift_w   = {hist_q, din};
  assign fill_full = (fill_q == FILL_MAX);
  assign hit       = din_valid && !pat_load && fill_full && (shift_w == pat_q);

  // Reset forces the strobe low in both output modes.
  assign y = rst_n && ((mode_moore == MODE_MOORE) ? y_q : hit);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    y_d    = hit;
    if (pat_load) begin
      pat_d  = pat;
      hist_d = '0;
      fill_d = '0;
      y_d    = 1'b0;
    end else if (din_valid) begin
      if (hit && !overlap_en) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = shift_w[PAT_W-2:0];
        fill_d = fill_full ? fill_q : fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q  <= PAT_DEFAULT;
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (pat_load),
    .inc  (hit),
    .cnt  (match_cnt),
    .sat  (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a default-width instance and a 2-bit-counter instance share stimulus.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic [3:0] pat = 4'b0000;
  logic       pat_load = 1'b0;
  logic       overlap_en = 1'b1;
  logic       mode_moore = 1'b0;

  logic       y;
  logic [7:0] match_cnt;
  logic       cnt_sat;
  logic       y2;
  logic [1:0] match_cnt2;
  logic       cnt_sat2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(4), .PAT_DEFAULT(4'b1101), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .pat(pat),
    .pat_load(pat_load), .overlap_en(overlap_en), .mode_moore(mode_moore),
    .y(y), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  seq_detect_param #(.PAT_W(4), .PAT_DEFAULT(4'b1101), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .pat(pat),
    .pat_load(pat_load), .overlap_en(overlap_en), .mode_moore(mode_moore),
    .y(y2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; sampling is 1 time unit later, well before the rising edge.
  task automatic drive(input logic d, input logic v);
    @(negedge clk);
    din       = d;
    din_valid = v;
    pat_load  = 1'b0;
    rst_n     = 1'b1;
    #1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    din       = 1'b0;
    pat_load  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk({tag, "_rst_y"}, y, 1'b0);
    chk({tag, "_rst_cnt"}, match_cnt, 8'd0);
  endtask

  initial begin
    logic [6:0] stream;
    logic [6:0] exp_y;
    stream = 7'b1101101;

    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] stream;
    logic [6:0] exp_y;
    stream = 7'b1101101;

    // Test 1: default pattern, Mealy, overlapping
    mode_moore = 1'b0;
    overlap_en = 1'b1;
    do_reset("t1");
    chk("t1_rst_sat", cnt_sat, 1'b0);
    exp_y = 7'b0001001;
    for (int i = 0; i < 7; i++) begin
      drive(stream[6-i], 1'b1);
      chk($sformatf("t1_y_bit%0d", i + 1), y, exp_y[6-i]);
    end
    drive(1'b0, 1'b0);
    chk("t1_cnt", match_cnt, 8'd2);
    chk("t1_y_idle", y, 1'b0);

    // Test 2: non-overlapping consumes the matched bits
    overlap_en = 1'b0;
    do_reset("t2");
    exp_y = 7'b0001000;
    for (int i = 0; i < 7; i++) begin
      drive(stream[6-i], 1'b1);
      chk($sformatf("t2_y_bit%0d", i + 1), y, exp_y[6-i]);
    end
    drive(1'b0, 1'b0);
    chk("t2_cnt", match_cnt, 8'd1);

    // Test 3: Moore, overlapping; pulse appears one cycle after each final bit
    overlap_en = 1'b1;
    mode_moore = 1'b1;
    do_reset("t3");
    exp_y = 7'b0000100;
    for (int i = 0; i < 7; i++) begin
      drive(stream[6-i], 1'b1);
      chk($sformatf("t3_y_bit%0d", i + 1), y, exp_y[6-i]);
    end
    drive(1'b0, 1'b0);
    chk("t3_y_after7", y, 1'b1);
    drive(1'b0, 1'b0);
    chk("t3_y_width", y, 1'b0);
    chk("t3_cnt", match_cnt, 8'd2);

    // Test 4: pattern load discards its own bit and the prior history; count carries 2 in
    mode_moore = 1'b0;
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    chk("t4_preload_cnt", match_cnt, 8'd2);
    @(negedge clk);
    pat       = 4'b0110;
    pat_load  = 1'b1;
    din       = 1'b0;
    din_valid = 1'b1;
    #1;
    chk("t4_load_y", y, 1'b0);
    exp_y = 7'b0000001;
    for (int i = 0; i < 4; i++) begin
      drive(exp_y[3] ^ (i == 1 || i == 2), 1'b1);
      if (i == 0) chk("t4_cnt_cleared", match_cnt, 8'd0);
      chk($sformatf("t4_y_bit%0d", i + 1), y, (i == 3) ? 1'b1 : 1'b0);
    end
    drive(1'b0, 1'b0);
    chk("t4_cnt", match_cnt, 8'd1);

    // Test 5: invalid cycles are gaps in the serial stream; reset restores 1101
    do_reset("t5");
    drive(1'b1, 1'b1);
    chk("t5_y_b1", y, 1'b0);
    drive(1'b1, 1'b1);
    chk("t5_y_b2", y, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0);
      chk($sformatf("t5_y_gap%0d", i), y, 1'b0);
    end
    drive(1'b0, 1'b1);
    chk("t5_y_b3", y, 1'b0);
    drive(1'b1, 1'b1);
    chk("t5_y_b4", y, 1'b1);
    drive(1'b0, 1'b0);
    chk("t5_cnt", match_cnt, 8'd1);

    // Test 6: 2-bit counter saturates at 3 after five overlapping hits
    do_reset("t6");
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    chk("t6_y2_first", y2, 1'b1);
    for (int r = 0; r < 4; r++) begin
      drive(1'b1, 1'b1);
      drive(1'b0, 1'b1);
      drive(1'b1, 1'b1);
      chk($sformatf("t6_y2_rep%0d", r), y2, 1'b1);
    end
    drive(1'b0, 1'b0);
    chk("t6_cnt2_sat", match_cnt2, 2'd3);
    chk("t6_sat2", cnt_sat2, 1'b1);
    chk("t6_cnt8", match_cnt, 8'd5);
    chk("t6_sat8", cnt_sat, 1'b0);

    // Reset in the middle of 1,1,0 then 1: reset blocks the strobe and flushes history
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    @(negedge clk);
    rst_n     = 1'b0;
    din       = 1'b1;
    din_valid = 1'b1;
    #1;
    chk("t6_rst_y_forced", y, 1'b0);
    drive(1'b1, 1'b1);
    chk("t6_post_rst_y", y, 1'b0);
    chk("t6_post_rst_cnt2", match_cnt2, 2'd0);
    chk("t6_post_rst_sat2", cnt_sat2, 1'b0);
    drive(1'b0, 1'b0);
    chk("t6_post_rst_cnt", match_cnt, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
